// File: rtl/amux_seq_pkg.sv
// amux_seq_pkg: shared state encoding, index width and one-hot helper for the mux scan sequencer
package amux_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BREAK   = 3'd1,
        SETTLE  = 3'd2,
        CONVERT = 3'd3,
        WAIT    = 3'd4
    } state_e;

    localparam int CH_IDX_W = 5;

    function automatic logic [31:0] onehot(input logic [CH_IDX_W-1:0] idx, input int n);
        return (int'(idx) < n) ? (32'd1 << idx) : 32'd0;
    endfunction

endpackage

// File: rtl/amux_seq_timer.sv
// amux_seq_timer: loadable saturating down-counter with a zero flag
module amux_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (dec_i && cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/amux_scan_sequencer.sv
// amux_scan_sequencer: walks analog mux channels with break-before-make, settle delay and SOC/EOC handshake
module amux_scan_sequencer
    import amux_seq_pkg::*;
#(
    parameter int channels       = 8,
    parameter int settle_cycles  = 4,
    parameter int timeout_cycles = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic                continuous,
    input  logic                eoc,
    output logic [channels-1:0] sel,
    output logic                soc,
    output logic [CH_IDX_W-1:0] ch_index,
    output logic                ch_done,
    output logic                scan_done,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [CH_IDX_W-1:0] LAST = CH_IDX_W'(channels - 1);

    state_e              state_q, state_d;
    logic [CH_IDX_W-1:0] idx_q, idx_d;
    logic [channels-1:0] sel_q, sel_d;
    logic                adv_q, adv_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                scan_q, scan_d;
    logic                soc_q;
    logic                s_zero, t_zero, last_ch;

    amux_seq_timer #(.W(8)) u_settle (
        .clk_i (clock),
        .rst_i (reset),
        .load_i(state_q == BREAK),
        .val_i (8'(settle_cycles - 1)),
        .dec_i (state_q == SETTLE),
        .zero_o(s_zero)
    );

    amux_seq_timer #(.W(16)) u_timeout (
        .clk_i (clock),
        .rst_i (reset),
        .load_i(state_d == CONVERT),
        .val_i (16'(timeout_cycles - 1)),
        .dec_i (state_q == CONVERT || state_q == WAIT),
        .zero_o(t_zero)
    );

    assign last_ch = idx_q == LAST;

    // adv_q defers the index step to the end of BREAK so ch_done still shows the finished channel
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        adv_d   = adv_q;
        err_d   = err_q;
        done_d  = 1'b0;
        scan_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = BREAK;
                idx_d   = '0;
                adv_d   = 1'b0;
                err_d   = 1'b0;
            end
            BREAK: begin
                state_d = (settle_cycles > 0) ? SETTLE : CONVERT;
                idx_d   = !adv_q ? idx_q : last_ch ? '0 : idx_q + 1'b1;
                adv_d   = 1'b0;
            end
            SETTLE:  state_d = s_zero ? CONVERT : SETTLE;
            CONVERT: state_d = WAIT;
            WAIT: if (eoc || t_zero) begin
                done_d  = eoc;
                scan_d  = last_ch;
                err_d   = err_q | ~eoc;
                adv_d   = 1'b1;
                state_d = (!last_ch || continuous) ? BREAK : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            idx_d   = idx_q;
            adv_d   = 1'b0;
            err_d   = err_q;
            done_d  = 1'b0;
            scan_d  = 1'b0;
        end
        sel_d = (state_d == SETTLE || state_d == CONVERT || state_d == WAIT)
              ? channels'(onehot(idx_d, channels)) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            adv_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            scan_q  <= 1'b0;
            soc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            adv_q   <= adv_d;
            err_q   <= err_d;
            done_q  <= done_d;
            scan_q  <= scan_d;
            soc_q   <= state_d == CONVERT;
        end
    end

    assign sel         = sel_q;
    assign soc         = soc_q;
    assign ch_index    = idx_q;
    assign ch_done     = done_q;
    assign scan_done   = scan_q;
    assign busy        = state_q != IDLE;
    assign timeout_err = err_q;

endmodule
